// File: rtl/denormalize_shift.sv
// Iterative log-shifter that restores a normalized word to a requested leading-zero count.
// Processes one count bit per cycle, MSB first, behind valid/ready handshakes.
module denormalize_shift #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_WORD,
  input  logic [CW-1:0]    i_COUNT,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_WORD,
  output logic             o_ERR
);

  localparam int KW = $clog2(CW);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg;
  logic [KW-1:0]    k;
  logic [CW-1:0]    step_amt;
  logic             count_over;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_VALID)      state_next = SHIFT;
      SHIFT:   if (k == '0)      state_next = DONE;
      DONE:    if (i_READY)      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  assign o_READY = (state == IDLE);
  assign o_VALID = (state == DONE);

  // 2^k reaches WIDTH on the top step; an oversized shift naturally yields zero.
  always_comb begin
    step_amt   = CW'(1) << k;
    shift_next = count_reg[k] ? (shift_reg >> step_amt) : shift_reg;
    count_over = (count_reg > WIDTH_C);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      shift_reg <= '0;
      count_reg <= '0;
      k         <= '0;
      o_WORD    <= '0;
      o_ERR     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_VALID) begin
            shift_reg <= i_WORD;
            count_reg <= i_COUNT;
            k         <= KW'(CW - 1);
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          k         <= k - KW'(1);
          if (k == '0) begin
            o_WORD <= count_over ? '0 : shift_next;
            o_ERR  <= count_over;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_denormalize_shift.sv
// Bench for denormalize_shift: directed vectors feed a scoreboard queue,
// and a monitor pops and compares on every result handshake.
module tb_denormalize_shift;
  localparam int WIDTH = 32;
  localparam int CW    = 6;

  logic             i_CLK = 1'b0;
  logic             i_RST = 1'b1;
  logic             i_VALID = 1'b0;
  logic             o_READY;
  logic [WIDTH-1:0] i_WORD = '0;
  logic [CW-1:0]    i_COUNT = '0;
  logic             o_VALID;
  logic             i_READY = 1'b1;
  logic [WIDTH-1:0] o_WORD;
  logic             o_ERR;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic             e;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  denormalize_shift #(.WIDTH(WIDTH), .CW(CW)) dut (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_VALID(i_VALID),
    .o_READY(o_READY),
    .i_WORD (i_WORD),
    .i_COUNT(i_COUNT),
    .o_VALID(o_VALID),
    .i_READY(i_READY),
    .o_WORD (o_WORD),
    .o_ERR  (o_ERR)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int clz(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w[i]) break;
      n++;
    end
    return n;
  endfunction

  // Monitor: a result handshake completes at the next rising edge.
  always @(negedge i_CLK) begin
    if (!i_RST && o_VALID && i_READY) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%h required=none", o_WORD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_word", o_WORD, e.w);
        chk("result_err", {31'b0, o_ERR}, {31'b0, e.e});
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [31:0] w, input logic [CW-1:0] c,
                      input logic [31:0] ew, input logic ee, input bit push);
    int n = 0;
    exp_t e;
    i_WORD  = w;
    i_COUNT = c;
    i_VALID = 1'b1;
    if (push) begin
      e.w = ew;
      e.e = ee;
      sb_q.push_back(e);
    end
    while (!o_READY && n < 100) begin
      @(posedge i_CLK); #1;
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge i_CLK); #1;
    i_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge i_CLK); #1;
      n++;
    end while (!o_VALID && n < 50);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !o_READY) && n < 200) begin
      @(posedge i_CLK); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] rw;
    logic [CW-1:0] rc;

    // Reset state
    #12;
    chk("rst_ready", {31'b0, o_READY}, 32'd1);
    chk("rst_valid", {31'b0, o_VALID}, 32'd0);
    chk("rst_word", o_WORD, 32'h0);
    chk("rst_err", {31'b0, o_ERR}, 32'd0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    @(posedge i_CLK); #1;

    // 1: basic operation and latency
    send(32'hA0008A28, 6'd3, 32'h14001145, 1'b0, 1'b1);
    wait_valid(n);
    chk("latency", 32'(n), 32'(CW));
    chk("roundtrip_clz", 32'(clz(o_WORD)), 32'd3);
    drain();

    // 2: boundaries
    send(32'h80000000, 6'd0,  32'h80000000, 1'b0, 1'b1); drain();
    send(32'h80000000, 6'd31, 32'h00000001, 1'b0, 1'b1); drain();
    send(32'h80000000, 6'd32, 32'h00000000, 1'b0, 1'b1); drain();
    send(32'h80000000, 6'd40, 32'h00000000, 1'b1, 1'b1); drain();
    send(32'h00000000, 6'd63, 32'h00000000, 1'b1, 1'b1); drain();
    send(32'hFFFFFFFF, 6'd33, 32'h00000000, 1'b1, 1'b1); drain();
    send(32'hC0000001, 6'd1,  32'h60000000, 1'b0, 1'b1); drain();

    // 3: backpressure
    i_READY = 1'b0;
    send(32'hFFFFFFFF, 6'd16, 32'h0000FFFF, 1'b0, 1'b1);
    wait_valid(n);
    chk("bp_valid_seen", {31'b0, o_VALID}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      i_VALID = 1'b1;
      i_WORD  = 32'h12345678;
      i_COUNT = 6'd0;
      @(negedge i_CLK);
      chk("bp_hold_valid", {31'b0, o_VALID}, 32'd1);
      chk("bp_hold_word", o_WORD, 32'h0000FFFF);
      chk("bp_hold_ready", {31'b0, o_READY}, 32'd0);
      @(posedge i_CLK); #1;
    end
    i_VALID = 1'b0;
    i_READY = 1'b1;
    @(posedge i_CLK); #1;
    chk("bp_release_ready", {31'b0, o_READY}, 32'd1);
    chk("bp_release_valid", {31'b0, o_VALID}, 32'd0);
    drain();

    // 4: back-to-back with i_VALID held high
    begin
      exp_t e;
      e.w = 32'h00F0F0F0; e.e = 1'b0; sb_q.push_back(e);
      e.w = 32'h00000001; e.e = 1'b0; sb_q.push_back(e);
      i_WORD = 32'hF0F0F000; i_COUNT = 6'd8; i_VALID = 1'b1;
      @(posedge i_CLK); #1;
      i_WORD = 32'h80000000; i_COUNT = 6'd31;
      n = 0;
      do begin
        @(posedge i_CLK); #1;
        n++;
      end while (!o_READY && n < 30);
      @(posedge i_CLK); #1;
      i_VALID = 1'b0;
      chk("b2b_spacing", 32'(n + 1), 32'(CW + 2));
      chk("b2b_second_taken", {31'b0, o_READY}, 32'd0);
      drain();
    end

    // 5: reset during the third SHIFT cycle
    send(32'hF0F0F0F0, 6'd5, 32'h0, 1'b0, 1'b0);
    @(posedge i_CLK);
    @(posedge i_CLK);
    #3 i_RST = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, o_VALID}, 32'd0);
    chk("midrst_ready", {31'b0, o_READY}, 32'd1);
    chk("midrst_word", o_WORD, 32'h0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    repeat (12) @(posedge i_CLK);
    #1;
    chk("midrst_no_stale", {31'b0, o_VALID}, 32'd0);
    send(32'h87654321, 6'd4, 32'h08765432, 1'b0, 1'b1);
    drain();

    // 6: random sweep
    for (int i = 0; i < 1000; i++) begin
      rw = $urandom | 32'h80000000;
      rc = CW'($urandom_range(0, 63));
      send(rw, rc, (rc >= 6'd32) ? 32'h0 : (rw >> rc), (rc > 6'd32), 1'b1);
    end
    drain();

    repeat (3) @(posedge i_CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
